coef_loader: RTL
================

# coef_loader

Sequencer that drives the write side of the coefficient buffer. On a `start` command it accepts exactly DEPTH coefficient words from a valid/ready stream, typically the output of the clock-domain-crossing FIFO. It turns each accepted word into a one-cycle `load` strobe with a 1-based `loadidx`, and pulses `done` when the full set has been written. It sits between the coefficient source and the buffer that feeds the FIR taps.

## Interface
- WIDTH, 27, coefficient word width in bits
- DEPTH, 4, number of coefficients per load sequence (≥1)

- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  begin a load sequence; sampled only in IDLE
- abort  input  1  cancel the sequence in progress; no `done` is produced
- in_valid  input  1  upstream word valid
- in_data  input  WIDTH  upstream coefficient word
- in_ready  output  1  loader accepts a word this cycle
- load  output  1  one-cycle write strobe to the buffer
- loadidx  output  $clog2(DEPTH)+1  target index, 1..DEPTH while `load`=1; 0 otherwise
- coef_data  output  WIDTH  word to write, valid while `load`=1
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse coincident with the final `load`

## Operation
- States: IDLE, LOAD.
- IDLE:
  - `in_ready`=0.
  - `start`=1 and `abort`=0 → LOAD, beat counter cnt := 1.
- LOAD:
  - `in_ready` = ~`abort` (combinational).
  - A beat is accepted when `in_valid`&`in_ready`.
  - On an accepted beat, these are registered for the next cycle: `load`:=1, `loadidx`:=cnt, `coef_data`:=`in_data`.
  - On an accepted beat with cnt<DEPTH: cnt := cnt+1.
  - On an accepted beat with cnt==DEPTH: `done`:=1 (registered, same cycle as that `load`), state → IDLE.
- `load`, `done` and the nonzero `loadidx` each last exactly one cycle. When no beat was accepted in the prior cycle, `load`=0, `loadidx`=0 and `done`=0. `coef_data` holds its last value.
- `busy` = (state==LOAD) | `load`. It stays high through the cycle carrying the final `load`/`done`.
- `abort` in LOAD:
  - State → IDLE, cnt cleared, no `done`.
  - Buffer entries already written are not undone.
  - A `load` registered from the previous cycle's beat still appears in the `abort` cycle.
- `start` while in LOAD is ignored. `start` and `abort` both high in IDLE: stay IDLE.
- `in_valid` while in IDLE is not accepted. Data is held upstream, never dropped or counted.
- cnt width is $clog2(DEPTH)+1 bits. It never wraps; the sequence ends at DEPTH. DEPTH=1 gives one beat, with `load`+`done` together.
- Reset:
  - State IDLE, cnt=0.
  - Outputs `in_ready`, `load`, `loadidx`, `coef_data`, `busy`, `done` all 0.
  - Reset mid-sequence abandons it with no `done`. Reset overrides `start` and `abort`.

## Timing
- `start` sampled at edge of cycle T → `in_ready`=1 in cycle T+1.
- Beat accepted in cycle k → `load`/`loadidx`/`coef_data` valid in cycle k+1. Latency is 1.
- Throughput is 1 beat per cycle, with no bubbles while `in_valid` stays high.
- Minimum sequence: `start` at T, beats T+1..T+DEPTH, final `load`+`done` at T+DEPTH+1, `busy` low at T+DEPTH+2.
- A new `start` is accepted in the cycle the final `load` is visible (state already IDLE). Its first `in_ready` is in the next cycle.
- Upstream stalls (`in_valid`=0) produce cycles with `load`=0. cnt is held across them.

## Test plan
- Back-to-back load, DEPTH=4:
  - Stimulus: `start` at cycle 0; `in_valid` high cycles 1–4 with data 0x11, 0x22, 0x33, 0x44.
  - Response: `load` in cycles 2–5 with `loadidx` 1, 2, 3, 4 and matching `coef_data`.
  - Response: `done` only in cycle 5; `busy` high cycles 1–5; `in_ready` low from cycle 5.
- Stalled stream:
  - Stimulus: `in_valid` pattern 1, 0, 0, 1, 1, 0, 1 after `start`.
  - Response: exactly 4 `load` pulses with `loadidx` 1..4 in order.
  - Response: no `load` in stall+1 cycles; `done` with the 4th.
- Abort mid-sequence:
  - Stimulus: `abort` after 2 beats have been accepted.
  - Response: the 2nd `load` still appears; no `done`; `in_ready`=0 in the `abort` cycle and after.
  - Response: a following `start` restarts at `loadidx`=1.
- Reset mid-sequence:
  - Stimulus: `reset` at beat 3.
  - Response: next cycle all outputs 0.
  - Response: `in_valid` with no new `start` is not accepted.
- Ignored commands:
  - Stimulus: `start` pulsed during LOAD.
  - Response: sequence unchanged.
  - Stimulus: `in_valid`=1 in IDLE.
  - Response: `in_ready`=0, no `load`.
  - Stimulus: `start`+`abort` together in IDLE.
  - Response: stays IDLE.
- DEPTH=1, WIDTH=8:
  - Stimulus: `start`, then one beat 0xA5.
  - Response: single cycle with `load`=1, `loadidx`=1, `coef_data`=0xA5, `done`=1.
  - Response: a new `start` accepted in that same cycle.

Source files
------------

// File: rtl/coef_loader_if.sv
// Valid/ready coefficient stream between the coefficient source and the loader.
interface coef_loader_if #(
  parameter int WIDTH = 27
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  // Source side: offers words, observes ready.
  modport master (
    output valid,
    output data,
    input  ready
  );

  // Sink side: consumes words, drives ready.
  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/coef_loader.sv
// Coefficient buffer write sequencer: on start, takes exactly DEPTH words from
// the stream and emits one registered load strobe per word with a 1-based
// index, flagging the final write with done.
module coef_loader #(
  parameter  int WIDTH = 27,
  parameter  int DEPTH = 4,
  localparam int IDXW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  coef_loader_if.slave     s_in,
  output logic             o_load,
  output logic [IDXW-1:0]  o_loadidx,
  output logic [WIDTH-1:0] o_coef_data,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Index of the last beat; cnt is wide enough to hold DEPTH without wrapping.
  localparam logic [IDXW-1:0] C_LAST = IDXW'(DEPTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDXW-1:0]  r_cnt;
  logic [IDXW-1:0]  w_cnt_next;
  logic             r_load;
  logic             w_load_next;
  logic [IDXW-1:0]  r_loadidx;
  logic [IDXW-1:0]  w_loadidx_next;
  logic [WIDTH-1:0] r_coef_data;
  logic [WIDTH-1:0] w_coef_data_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_ready;

  // State, beat counter and registered write-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_load      <= 1'b0;
      r_loadidx   <= '0;
      r_coef_data <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_load      <= w_load_next;
      r_loadidx   <= w_loadidx_next;
      r_coef_data <= w_coef_data_next;
      r_done      <= w_done_next;
    end
  end

  // Next-state logic: abort wins over any beat and also drops ready, so no
  // word is consumed in the abort cycle.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_ready          = 1'b0;
    w_load_next      = 1'b0;
    w_loadidx_next   = '0;
    w_coef_data_next = r_coef_data;
    w_done_next      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_state_next = LOAD;
          w_cnt_next   = IDXW'(1);
        end
      end
      LOAD: begin
        w_ready = !i_abort;
        if (i_abort) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (s_in.valid) begin
          w_load_next      = 1'b1;
          w_loadidx_next   = r_cnt;
          w_coef_data_next = s_in.data;
          if (r_cnt == C_LAST) begin
            w_done_next  = 1'b1;
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + IDXW'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign s_in.ready  = w_ready;
  assign o_load      = r_load;
  assign o_loadidx   = r_loadidx;
  assign o_coef_data = r_coef_data;
  assign o_done      = r_done;
  // Busy covers the trailing cycle that carries the final load/done.
  assign o_busy      = (r_state == LOAD) | r_load;

endmodule
